// File: rtl/axis_pkg.sv
// Shared constants, FSM state type and tkeep helper for the AXIS packet path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axis_pkg;

    localparam int DATA_W      = 64;
    localparam int KEEP_W      = 8;
    localparam int LEN_W       = 16;
    localparam int BEAT_W      = 13;   // ceil(MAX_LEN/8) fits with headroom
    localparam int MAX_LEN_DEF = 9000;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Byte enables for the final beat: rem == 0 means the beat is full.
    function automatic logic [KEEP_W-1:0] keep_from_rem(input logic [2:0] rem);
        logic [KEEP_W-1:0] keep;
        for (int i = 0; i < KEEP_W; i++) begin
            keep[i] = (rem == 3'd0) || (i < int'(rem));
        end
        return keep;
    endfunction

endpackage

// File: rtl/axis_beat_builder.sv
// Builds one 64-bit payload beat: byte lane i = seed + beat_idx*8 + i, masked by tkeep.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
// Ports: seed/beat_idx/is_last/rem in; tdata/tkeep out.
module axis_beat_builder
    import axis_pkg::*;
(
    input  logic [7:0]        seed,
    input  logic [BEAT_W-1:0] beat_idx,
    input  logic              is_last,
    input  logic [2:0]        rem,
    output logic [DATA_W-1:0] tdata,
    output logic [KEEP_W-1:0] tkeep
);

    logic [7:0] base;

    always_comb begin
        // Only beat_idx*8 mod 256 matters because the payload wraps at 8 bits.
        base  = seed + 8'(beat_idx << 3);
        tkeep = is_last ? keep_from_rem(rem) : {KEEP_W{1'b1}};
        tdata = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            if (tkeep[i]) begin
                tdata[i*8 +: 8] = base + 8'(i);
            end
        end
    end

endmodule

// File: rtl/axis_packet_gen.sv
// Accepts (len, seed) commands and emits one AXI4-Stream packet per legal command.
// Latency: first beat valid the cycle after the command handshake; one idle cycle between packets.
// Backpressure: beats held stable while m_axis_tready is low; cmd_ready low while a packet is in flight.
// Ports: cmd_* command handshake, m_axis_* stream out, pkt_done/cmd_err pulses, pkt_count statistic.
module axis_packet_gen
    import axis_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
    input  logic              axis_aclk,
    input  logic              axis_aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [7:0]        cmd_seed,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              pkt_done,
    output logic              cmd_err,
    output logic [31:0]       pkt_count
);

    state_e            state_q, state_d;
    logic [7:0]        seed_q, seed_d;
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic [BEAT_W-1:0] beat_idx_q, beat_idx_d;
    logic [2:0]        rem_q, rem_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic [KEEP_W-1:0] tkeep_q, tkeep_d;
    logic              pkt_done_q, pkt_done_d;
    logic              cmd_err_q, cmd_err_d;
    logic [31:0]       pkt_count_q, pkt_count_d;

    logic              len_ok;
    logic              beat_hs;
    logic [BEAT_W-1:0] beats_calc;

    logic [7:0]        bb_seed;
    logic [BEAT_W-1:0] bb_idx;
    logic              bb_last;
    logic [2:0]        bb_rem;
    logic [DATA_W-1:0] bb_tdata;
    logic [KEEP_W-1:0] bb_tkeep;

    assign len_ok     = (cmd_len != '0) && ({16'd0, cmd_len} <= MAX_LEN);
    assign beats_calc = BEAT_W'((cmd_len + LEN_W'(7)) >> 3);
    assign beat_hs    = tvalid_q && m_axis_tready;

    // In IDLE the builder prepares beat 0 straight from the command so it can be
    // registered on the handshake; in SEND it always prepares the following beat.
    always_comb begin
        if (state_q == IDLE) begin
            bb_seed = cmd_seed;
            bb_idx  = '0;
            bb_last = (beats_calc == BEAT_W'(1));
            bb_rem  = cmd_len[2:0];
        end else begin
            bb_seed = seed_q;
            bb_idx  = beat_idx_q + BEAT_W'(1);
            bb_last = ((beat_idx_q + BEAT_W'(1)) == (beats_q - BEAT_W'(1)));
            bb_rem  = rem_q;
        end
    end

    axis_beat_builder u_beat_builder (
        .seed     (bb_seed),
        .beat_idx (bb_idx),
        .is_last  (bb_last),
        .rem      (bb_rem),
        .tdata    (bb_tdata),
        .tkeep    (bb_tkeep)
    );

    // State register
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_valid && len_ok)  state_d = SEND;
            SEND:    if (beat_hs && tlast_q)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        cmd_ready   = 1'b0;
        seed_d      = seed_q;
        beats_d     = beats_q;
        beat_idx_d  = beat_idx_q;
        rem_d       = rem_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        pkt_done_d  = 1'b0;
        cmd_err_d   = 1'b0;
        pkt_count_d = pkt_count_q;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (len_ok) begin
                        seed_d     = cmd_seed;
                        beats_d    = beats_calc;
                        rem_d      = cmd_len[2:0];
                        beat_idx_d = '0;
                        tvalid_d   = 1'b1;
                        tdata_d    = bb_tdata;
                        tkeep_d    = bb_tkeep;
                        tlast_d    = bb_last;
                    end else begin
                        cmd_err_d  = 1'b1;
                    end
                end
            end
            SEND: begin
                if (beat_hs) begin
                    if (tlast_q) begin
                        tvalid_d    = 1'b0;
                        tlast_d     = 1'b0;
                        tdata_d     = '0;
                        tkeep_d     = '0;
                        pkt_done_d  = 1'b1;
                        pkt_count_d = pkt_count_q + 32'd1;
                    end else begin
                        beat_idx_d  = beat_idx_q + BEAT_W'(1);
                        tdata_d     = bb_tdata;
                        tkeep_d     = bb_tkeep;
                        tlast_d     = bb_last;
                    end
                end
            end
            default: ;
        endcase
    end

    // Async reset drops tvalid immediately, abandoning any packet in flight.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            seed_q      <= '0;
            beats_q     <= '0;
            beat_idx_q  <= '0;
            rem_q       <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            pkt_done_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            seed_q      <= seed_d;
            beats_q     <= beats_d;
            beat_idx_q  <= beat_idx_d;
            rem_q       <= rem_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            pkt_done_q  <= pkt_done_d;
            cmd_err_q   <= cmd_err_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
    assign pkt_done      = pkt_done_q;
    assign cmd_err       = cmd_err_q;
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_axis_packet_gen.sv
// Self-checking bench for axis_packet_gen: command table, scoreboard of expected beats,
// stall-stability and pulse monitors, plus back-to-back and mid-packet reset sequences.
module tb_axis_packet_gen;

    localparam int MAX_LEN = 9000;

    logic        axis_aclk;
    logic        axis_aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_len;
    logic [7:0]  cmd_seed;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        pkt_done;
    logic        cmd_err;
    logic [31:0] pkt_count;

    axis_packet_gen #(.MAX_LEN(MAX_LEN)) dut (
        .axis_aclk     (axis_aclk),
        .axis_aresetn  (axis_aresetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_len       (cmd_len),
        .cmd_seed      (cmd_seed),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .pkt_done      (pkt_done),
        .cmd_err       (cmd_err),
        .pkt_count     (pkt_count)
    );

    initial begin
        axis_aclk = 1'b0;
        forever #5 axis_aclk = ~axis_aclk;
    end

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        int          plen;
    } sb_t;

    typedef struct {
        logic [15:0] len;
        logic [7:0]  seed;
        logic        exp_err;
        int          exp_beats;
        logic [7:0]  exp_last_keep;
        logic [63:0] exp_first;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[8];

    int checks = 0;
    int failures = 0;

    logic        mon_en = 1'b0;
    logic        rand_rdy = 1'b0;
    int          exp_pkts = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          tvalid_cycles = 0;
    int          cur_beats = 0;
    int          cur_bytes = 0;
    logic [63:0] cur_first = '0;
    int          last_beats = 0;
    logic [63:0] last_first = '0;
    logic [7:0]  last_keep = '0;
    int          idle_run = 0;
    int          last_gap = 0;
    logic        err_pend = 1'b0;
    logic        done_pend = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] stall_data = '0;
    logic [9:0]  stall_ctl = '0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endfunction

    // Reference model: byte k = seed + k, lanes past the packet end are zero.
    function automatic void push_pkt(input int len, input logic [7:0] seed);
        int beats;
        beats = (len + 7) / 8;
        for (int b = 0; b < beats; b++) begin
            sb_t e;
            e.data = '0;
            e.keep = '0;
            for (int i = 0; i < 8; i++) begin
                if (b * 8 + i < len) begin
                    e.data[i*8 +: 8] = seed + 8'(b * 8 + i);
                    e.keep[i]        = 1'b1;
                end
            end
            e.last = (b == beats - 1);
            e.plen = len;
            sb_q.push_back(e);
        end
    endfunction

    // Monitors sample on the falling edge, half a cycle away from DUT updates.
    always @(negedge axis_aclk) begin
        if (!mon_en) begin
            cur_beats  = 0;
            cur_bytes  = 0;
            prev_stall = 1'b0;
            err_pend   = 1'b0;
            done_pend  = 1'b0;
            idle_run   = 0;
        end else begin
            if (cmd_err || err_pend) chk("cmd_err_pulse", 64'(cmd_err), 64'(err_pend));
            if (cmd_err) err_cnt++;
            err_pend = 1'b0;
            if (cmd_valid && cmd_ready) begin
                if (cmd_len == 16'd0 || int'(cmd_len) > MAX_LEN) err_pend = 1'b1;
                else push_pkt(int'(cmd_len), cmd_seed);
            end

            if (pkt_done || done_pend) chk("pkt_done_pulse", 64'(pkt_done), 64'(done_pend));
            if (pkt_done) done_cnt++;
            done_pend = 1'b0;

            if (prev_stall) begin
                chk("stall_hold_data", m_axis_tdata, stall_data);
                chk("stall_hold_ctl", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tkeep}), 64'(stall_ctl));
            end

            if (m_axis_tvalid) begin
                tvalid_cycles++;
                if (idle_run > 0) last_gap = idle_run;
                idle_run = 0;
            end else begin
                idle_run++;
            end

            if (m_axis_tvalid && m_axis_tready) begin
                chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    sb_t e;
                    e = sb_q.pop_front();
                    chk("tdata", m_axis_tdata, e.data);
                    chk("tkeep", 64'(m_axis_tkeep), 64'(e.keep));
                    chk("tlast", 64'(m_axis_tlast), 64'(e.last));
                    if (cur_beats == 0) cur_first = m_axis_tdata;
                    cur_beats++;
                    cur_bytes += $countones(m_axis_tkeep);
                    if (m_axis_tlast) begin
                        chk("len_monitor", 64'(cur_bytes), 64'(e.plen));
                        last_beats = cur_beats;
                        last_first = cur_first;
                        last_keep  = m_axis_tkeep;
                        cur_beats  = 0;
                        cur_bytes  = 0;
                        done_pend  = 1'b1;
                    end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            stall_data = m_axis_tdata;
            stall_ctl  = {m_axis_tvalid, m_axis_tlast, m_axis_tkeep};
        end
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge axis_aclk);
            #1;
            m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_cmd(input logic [15:0] len, input logic [7:0] seed);
        int t;
        @(posedge axis_aclk);
        #1;
        t = 0;
        while (!cmd_ready && t < 3000) begin
            @(posedge axis_aclk);
            #1;
            t++;
        end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_len   = len;
        cmd_seed  = seed;
        @(posedge axis_aclk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int start;
        int t;
        start = done_cnt;
        t = 0;
        while (done_cnt == start && t < 3000) begin
            @(posedge axis_aclk);
            #2;
            t++;
        end
        chk(nm, 64'(done_cnt != start), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int v0;
        int t;

        vecs[0] = '{16'd64,   8'h00, 1'b0, 8,    8'hFF, 64'h0706050403020100};
        vecs[1] = '{16'd13,   8'hFE, 1'b0, 2,    8'h1F, 64'h050403020100FFFE};
        vecs[2] = '{16'd1,    8'h5A, 1'b0, 1,    8'h01, 64'h000000000000005A};
        vecs[3] = '{16'd0,    8'h11, 1'b1, 0,    8'h00, 64'h0};
        vecs[4] = '{16'd9001, 8'h22, 1'b1, 0,    8'h00, 64'h0};
        vecs[5] = '{16'd9000, 8'h03, 1'b0, 1125, 8'hFF, 64'h0A09080706050403};
        vecs[6] = '{16'd8,    8'h80, 1'b0, 1,    8'hFF, 64'h8786858483828180};
        vecs[7] = '{16'd9,    8'h00, 1'b0, 2,    8'h01, 64'h0706050403020100};

        axis_aresetn = 1'b0;
        cmd_valid    = 1'b0;
        cmd_len      = '0;
        cmd_seed     = '0;
        repeat (3) @(posedge axis_aclk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_tkeep_tlast", 64'({m_axis_tkeep, m_axis_tlast}), 64'd0);
        chk("rst_pulses", 64'({pkt_done, cmd_err}), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        axis_aresetn = 1'b1;
        mon_en       = 1'b1;

        // Command table
        for (int v = 0; v < 8; v++) begin
            e0 = err_cnt;
            v0 = tvalid_cycles;
            send_cmd(vecs[v].len, vecs[v].seed);
            if (vecs[v].exp_err) begin
                repeat (3) @(posedge axis_aclk);
                #2;
                chk("err_count", 64'(err_cnt - e0), 64'd1);
                chk("err_no_tvalid", 64'(tvalid_cycles - v0), 64'd0);
            end else begin
                exp_pkts++;
                wait_done("pkt_done_wait");
                chk("beats", 64'(last_beats), 64'(vecs[v].exp_beats));
                chk("first_tdata", last_first, vecs[v].exp_first);
                chk("last_tkeep", 64'(last_keep), 64'(vecs[v].exp_last_keep));
                chk("no_err", 64'(err_cnt - e0), 64'd0);
            end
            chk("pkt_count", 64'(pkt_count), 64'(exp_pkts));
        end

        // Random backpressure on a 24-byte packet
        rand_rdy = 1'b1;
        send_cmd(16'd24, 8'h77);
        exp_pkts++;
        wait_done("rand_done_wait");
        rand_rdy = 1'b0;
        chk("rand_beats", 64'(last_beats), 64'd3);
        chk("rand_first", last_first, 64'h7E7D7C7B7A797877);
        chk("rand_pkt_count", 64'(pkt_count), 64'(exp_pkts));

        // Back-to-back with cmd_valid held: one idle cycle between packets
        @(posedge axis_aclk);
        #1;
        cmd_valid = 1'b1;
        cmd_len   = 16'd16;
        cmd_seed  = 8'hC0;
        wait_done("b2b_first_done");
        cmd_valid = 1'b0;
        wait_done("b2b_second_done");
        exp_pkts += 2;
        chk("b2b_gap", 64'(last_gap), 64'd1);
        chk("b2b_pkt_count", 64'(pkt_count), 64'(exp_pkts));

        // Reset while beat 2 of 8 is on the bus
        send_cmd(16'd64, 8'h30);
        t = 0;
        while (cur_beats != 2 && t < 100) begin
            @(posedge axis_aclk);
            #2;
            t++;
        end
        chk("beat2_reached", 64'(cur_beats), 64'd2);
        chk("beat2_tdata", m_axis_tdata, 64'h4746454443424140);
        axis_aresetn = 1'b0;
        mon_en       = 1'b0;
        #1;
        chk("async_tvalid_drop", 64'(m_axis_tvalid), 64'd0);
        chk("async_tlast_drop", 64'(m_axis_tlast), 64'd0);
        sb_q.delete();
        exp_pkts = 0;
        repeat (2) @(posedge axis_aclk);
        #1;
        axis_aresetn = 1'b1;
        mon_en       = 1'b1;
        chk("post_rst_ready", 64'(cmd_ready), 64'd1);
        chk("post_rst_count", 64'(pkt_count), 64'd0);
        send_cmd(16'd8, 8'h30);
        exp_pkts++;
        wait_done("post_rst_done");
        chk("post_rst_first", last_first, 64'h3736353433323130);
        chk("post_rst_beats", 64'(last_beats), 64'd1);
        chk("post_rst_pkt_count", 64'(pkt_count), 64'(exp_pkts));

        repeat (3) @(posedge axis_aclk);
        #2;
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
